// File: rtl/seg7_scanner.sv
// Eight-digit multiplexed seven-segment driver for the CPU display register.
// Captures the value once per scan frame and blinks the whole display while halted.
module seg7_scanner #(
  parameter int DIV          = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] display,
  input  logic        halt,
  input  logic        blank_lead,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [FW-1:0] FMAX = FW'(BLINK_FRAMES - 1);

  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      4'hF:    s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          phase_q, phase_d;
  logic          fb_q, fb_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_q, frame_d;

  logic          tick_s, boundary_s, dark_s, blank_s;
  logic [3:0]    nib_s;
  logic [31:0]   upper_s;

  // Next-state and output decode; outputs use the pre-edge scan state.
  always_comb begin
    tick_s     = (pcnt_q == PMAX);
    boundary_s = tick_s && (idx_q == 3'd7);
    pcnt_d     = tick_s ? {PW{1'b0}} : pcnt_q + PW'(1);
    idx_d      = tick_s ? idx_q + 3'd1 : idx_q;
    shadow_d   = boundary_s ? display : shadow_q;
    fb_d       = boundary_s;

    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (!halt) begin
      fcnt_d  = {FW{1'b0}};
      phase_d = 1'b0;
    end else if (boundary_s) begin
      if (fcnt_q == FMAX) begin
        fcnt_d  = {FW{1'b0}};
        phase_d = ~phase_q;
      end else begin
        fcnt_d  = fcnt_q + FW'(1);
      end
    end else begin
      fcnt_d  = fcnt_q;
    end

    nib_s   = shadow_q[{idx_q, 2'b00} +: 4];
    // Digit idx is a leading zero when it and every higher nibble are zero.
    upper_s = shadow_q >> {idx_q, 2'b00};
    blank_s = blank_lead && (idx_q != 3'd0) && (upper_s == 32'd0);
    dark_s  = halt && phase_q;

    if (dark_s || blank_s) begin
      an_d  = 8'hFF;
      seg_d = 7'h7F;
    end else begin
      an_d  = ~(8'd1 << idx_q);
      seg_d = hex_decode(nib_s);
    end
    dp_d    = ~((idx_q == 3'd0) && halt && !phase_q);
    frame_d = fb_q;
  end

  // State and registered output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q   <= {PW{1'b0}};
      idx_q    <= 3'd0;
      shadow_q <= 32'd0;
      fcnt_q   <= {FW{1'b0}};
      phase_q  <= 1'b0;
      fb_q     <= 1'b0;
      an_q     <= 8'hFF;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      frame_q  <= 1'b0;
    end else begin
      pcnt_q   <= pcnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      fcnt_q   <= fcnt_d;
      phase_q  <= phase_d;
      fb_q     <= fb_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      frame_q  <= frame_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scanner.sv
// Scoreboard bench for seg7_scanner: three instances (DIV=2, DIV=1, DIV=5)
// exercised in turn; expected outputs are queued per cycle and checked on negedge.
module tb_seg7_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst0, rst1, rst2;
  logic [31:0] disp0, disp1, disp2;
  logic        halt0, halt1, halt2;
  logic        bl0, bl1, bl2;
  logic [7:0]  an0, an1, an2;
  logic [6:0]  seg0, seg1, seg2;
  logic        dp0, dp1, dp2;
  logic        fr0, fr1, fr2;

  seg7_scanner #(.DIV(2), .BLINK_FRAMES(2)) u_dut0 (
    .clk(clk), .rst(rst0), .display(disp0), .halt(halt0), .blank_lead(bl0),
    .an(an0), .seg(seg0), .dp(dp0), .frame(fr0));
  seg7_scanner #(.DIV(1), .BLINK_FRAMES(2)) u_dut1 (
    .clk(clk), .rst(rst1), .display(disp1), .halt(halt1), .blank_lead(bl1),
    .an(an1), .seg(seg1), .dp(dp1), .frame(fr1));
  seg7_scanner #(.DIV(5), .BLINK_FRAMES(4)) u_dut2 (
    .clk(clk), .rst(rst2), .display(disp2), .halt(halt2), .blank_lead(bl2),
    .an(an2), .seg(seg2), .dp(dp2), .frame(fr2));

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    int          cyc;
    int          inst;
    logic [16:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void push(int c, int inst, logic [7:0] a, logic [6:0] s,
                               logic d, logic f, string name);
    exp_t e;
    e.cyc  = c;
    e.inst = inst;
    e.exp  = {a, s, d, f};
    e.name = name;
    sb_q.push_back(e);
  endfunction

  // One full scan frame of expected outputs starting at cycle 'start'.
  function automatic void expect_frame(int inst, int start, int div, logic [31:0] val,
                                       logic bl, logic [7:0] halt_m, logic [7:0] dark_m,
                                       logic pulse, string name);
    for (int k = 0; k < 8; k++) begin
      logic [3:0] nib;
      logic       blank;
      logic       off;
      logic [7:0] a;
      nib   = val[4*k +: 4];
      blank = bl && (k != 0);
      for (int m = k; m < 8; m++)
        if (val[4*m +: 4] != 4'h0) blank = 1'b0;
      off = blank || dark_m[k];
      a   = 8'h01 << k;
      for (int j = 0; j < div; j++)
        push(start + k*div + j, inst, off ? 8'hFF : ~a, off ? 7'h7F : SEG_TAB[nib],
             (k == 0 && halt_m[k] && !dark_m[k]) ? 1'b0 : 1'b1,
             pulse && (k == 0) && (j == 0), name);
    end
  endfunction

  exp_t        mon_e;
  logic [16:0] mon_act;

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      mon_e = sb_q.pop_front();
      case (mon_e.inst)
        0:       mon_act = {an0, seg0, dp0, fr0};
        1:       mon_act = {an1, seg1, dp1, fr1};
        default: mon_act = {an2, seg2, dp2, fr2};
      endcase
      n_cmp++;
      if (mon_e.cyc != cyc || mon_act !== mon_e.exp) begin
        n_bad++;
        $display("FAIL %s inst%0d cyc=%0d(at %0d): an/seg/dp/frame got %h/%h/%b/%b want %h/%h/%b/%b",
                 mon_e.name, mon_e.inst, mon_e.cyc, cyc,
                 mon_act[16:9], mon_act[8:2], mon_act[1], mon_act[0],
                 mon_e.exp[16:9], mon_e.exp[8:2], mon_e.exp[1], mon_e.exp[0]);
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int r0, r1, r2;

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    disp0 = 32'h89ABCDEF; disp1 = 32'h01234567; disp2 = 32'hDEADBEEF;
    halt0 = 1'b0; halt1 = 1'b0; halt2 = 1'b0;
    bl0 = 1'b0; bl1 = 1'b0; bl2 = 1'b0;

    wait_cyc(3);
    push(3, 0, 8'hFF, 7'h7F, 1'b1, 1'b0, "reset0");
    push(3, 1, 8'hFF, 7'h7F, 1'b1, 1'b0, "reset1");
    push(3, 2, 8'hFF, 7'h7F, 1'b1, 1'b0, "reset2");

    // DIV=2: scan order, frame period, tear-free capture, blanking
    r0 = 4;
    wait_cyc(r0);
    rst0 = 1'b0;
    push(r0, 0, 8'hFF, 7'h7F, 1'b1, 1'b0, "reset_hold0");
    expect_frame(0, r0 + 1,  2, 32'h0,        1'b0, 8'h00, 8'h00, 1'b0, "first_frame");
    expect_frame(0, r0 + 17, 2, 32'h89ABCDEF, 1'b0, 8'h00, 8'h00, 1'b1, "scan");
    expect_frame(0, r0 + 33, 2, 32'h89ABCDEF, 1'b0, 8'h00, 8'h00, 1'b1, "scan2");
    wait_cyc(r0 + 40);
    disp0 = 32'h11111111;
    expect_frame(0, r0 + 49, 2, 32'h11111111, 1'b0, 8'h00, 8'h00, 1'b1, "tear_old");
    wait_cyc(r0 + 55);
    disp0 = 32'h22222222;
    expect_frame(0, r0 + 65, 2, 32'h22222222, 1'b0, 8'h00, 8'h00, 1'b1, "tear_new");
    wait_cyc(r0 + 70);
    disp0 = 32'h00000A50;
    bl0   = 1'b1;
    expect_frame(0, r0 + 81, 2, 32'h00000A50, 1'b1, 8'h00, 8'h00, 1'b1, "blank_lead");
    wait_cyc(r0 + 88);
    disp0 = 32'h0;
    expect_frame(0, r0 + 97, 2, 32'h0,        1'b1, 8'h00, 8'h00, 1'b1, "blank_zero");

    // DIV=1, BLINK_FRAMES=2: per-cycle scan and halt blink
    r1 = r0 + 113;
    wait_cyc(r1);
    rst1 = 1'b0;
    push(r1, 1, 8'hFF, 7'h7F, 1'b1, 1'b0, "reset_hold1");
    expect_frame(1, r1 + 1,  1, 32'h0,        1'b0, 8'h00, 8'h00, 1'b0, "div1_first");
    expect_frame(1, r1 + 9,  1, 32'h01234567, 1'b0, 8'h00, 8'h00, 1'b1, "div1_scan");
    expect_frame(1, r1 + 17, 1, 32'h01234567, 1'b0, 8'h00, 8'h00, 1'b1, "div1_scan2");
    wait_cyc(r1 + 24);
    halt1 = 1'b1;
    expect_frame(1, r1 + 25, 1, 32'h01234567, 1'b0, 8'hFF, 8'h00, 1'b1, "halt_lit");
    expect_frame(1, r1 + 33, 1, 32'h01234567, 1'b0, 8'hFF, 8'h00, 1'b1, "halt_lit");
    expect_frame(1, r1 + 41, 1, 32'h01234567, 1'b0, 8'hFF, 8'hFF, 1'b1, "halt_dark");
    expect_frame(1, r1 + 49, 1, 32'h01234567, 1'b0, 8'hFF, 8'hFF, 1'b1, "halt_dark");
    expect_frame(1, r1 + 57, 1, 32'h01234567, 1'b0, 8'hFF, 8'h00, 1'b1, "halt_lit2");
    expect_frame(1, r1 + 65, 1, 32'h01234567, 1'b0, 8'hFF, 8'h00, 1'b1, "halt_lit2");
    expect_frame(1, r1 + 73, 1, 32'h01234567, 1'b0, 8'h0F, 8'h0F, 1'b1, "halt_drop");
    wait_cyc(r1 + 76);
    halt1 = 1'b0;
    expect_frame(1, r1 + 81, 1, 32'h01234567, 1'b0, 8'h00, 8'h00, 1'b1, "unhalted");
    wait_cyc(r1 + 88);
    halt1 = 1'b1;
    expect_frame(1, r1 + 89,  1, 32'h01234567, 1'b0, 8'hFF, 8'h00, 1'b1, "rehalt_lit");
    expect_frame(1, r1 + 97,  1, 32'h01234567, 1'b0, 8'hFF, 8'h00, 1'b1, "rehalt_lit");
    expect_frame(1, r1 + 105, 1, 32'h01234567, 1'b0, 8'hFF, 8'hFF, 1'b1, "rehalt_dark");

    // DIV=5: asynchronous reset in the middle of a slot
    r2 = r1 + 113;
    wait_cyc(r2);
    rst2 = 1'b0;
    push(r2, 2, 8'hFF, 7'h7F, 1'b1, 1'b0, "reset_hold2");
    for (int c = 1; c <= 5; c++) push(r2 + c, 2, 8'hFE, 7'h40, 1'b0 ^ 1'b1, 1'b0, "pre_async");
    push(r2 + 6, 2, 8'hFD, 7'h40, 1'b1, 1'b0, "pre_async");
    wait_cyc(r2 + 7);
    #2;
    rst2 = 1'b1;
    push(r2 + 7, 2, 8'hFF, 7'h7F, 1'b1, 1'b0, "async_rst");
    push(r2 + 8, 2, 8'hFF, 7'h7F, 1'b1, 1'b0, "async_hold");
    wait_cyc(r2 + 9);
    rst2 = 1'b0;
    push(r2 + 9, 2, 8'hFF, 7'h7F, 1'b1, 1'b0, "async_release");
    expect_frame(2, r2 + 10, 5, 32'h0,        1'b0, 8'h00, 8'h00, 1'b0, "post_rst");
    expect_frame(2, r2 + 50, 5, 32'hDEADBEEF, 1'b0, 8'h00, 8'h00, 1'b1, "div5_scan");

    wait_cyc(r2 + 95);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: %0d expectations unchecked, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
